// File: rtl/dvi_palette_lut.sv
// Multi-channel palette lookup for the DVI pixel path: per-channel RAM copies with byte-lane
// writes, valid/blank pipeline. Define DVI_PALETTE_WR_FORWARD_EN for same-cycle write forwarding.
module dvi_palette_lut #(
  parameter int unsigned W_ADDR  = 8,
  parameter int unsigned W_DATA  = 24,
  parameter int unsigned N_CH    = 2,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wen,
  input  logic [W_ADDR-1:0]        waddr,
  input  logic [W_DATA-1:0]        wdata,
  input  logic [W_DATA/8-1:0]      wmask,
  input  logic                     in_valid,
  input  logic                     in_blank,
  input  logic [N_CH*W_ADDR-1:0]   in_index,
  output logic                     out_valid,
  output logic                     out_blank,
  output logic [N_CH*W_DATA-1:0]   out_data
);

  localparam int unsigned Depth  = 1 << W_ADDR;
  localparam int unsigned NLanes = W_DATA / 8;

  logic                   v1_q;
  logic                   b1_q;
  logic [N_CH*W_DATA-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      b1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      b1_q <= in_blank;
    end
  end

`ifdef DVI_PALETTE_WR_FORWARD_EN
  // Write payload captured with the read so the lane mux sees the colliding write.
  logic [W_DATA-1:0] fwd_data_q;
  logic [NLanes-1:0] fwd_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else if (in_valid) begin
      fwd_data_q <= wdata;
      fwd_mask_q <= wmask;
    end
  end
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [W_DATA-1:0] mem [Depth];
    logic [W_ADDR-1:0] idx;
    logic [W_DATA-1:0] rd_q;
    logic [W_DATA-1:0] merged;

    assign idx = in_index[c*W_ADDR +: W_ADDR];

    // Storage has no reset so it maps onto block RAM and survives rst_n.
    always_ff @(posedge clk) begin
      if (wen) begin
        for (int k = 0; k < NLanes; k++) begin
          if (wmask[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else if (in_valid) begin
        rd_q <= mem[idx];
      end
    end

`ifdef DVI_PALETTE_WR_FORWARD_EN
    logic hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hit_q <= 1'b0;
      end else if (in_valid) begin
        hit_q <= wen && (idx == waddr);
      end
    end

    always_comb begin
      merged = rd_q;
      for (int k = 0; k < NLanes; k++) begin
        if (hit_q && fwd_mask_q[k]) merged[8*k +: 8] = fwd_data_q[8*k +: 8];
      end
    end
`else
    assign merged = rd_q;
`endif

    assign s1_data[c*W_DATA +: W_DATA] = b1_q ? '0 : merged;
  end

  if (OUT_REG == 1) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_blank <= 1'b0;
        out_data  <= '0;
      end else begin
        out_valid <= v1_q;
        out_blank <= b1_q;
        out_data  <= s1_data;
      end
    end
  end else begin : g_out_comb
    assign out_valid = v1_q;
    assign out_blank = b1_q;
    assign out_data  = s1_data;
  end

endmodule

// File: tb/tb_dvi_palette_lut.sv
// Directed self-checking bench for dvi_palette_lut (default parameters, L = 2).
`timescale 1ns/1ps
module tb_dvi_palette_lut;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  waddr = '0;
  logic [23:0] wdata = '0;
  logic [2:0]  wmask = '0;
  logic        in_valid = 1'b0;
  logic        in_blank = 1'b0;
  logic [15:0] in_index = '0;
  logic        out_valid;
  logic        out_blank;
  logic [47:0] out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dvi_palette_lut #(
    .W_ADDR (8),
    .W_DATA (24),
    .N_CH   (2),
    .OUT_REG(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .wmask    (wmask),
    .in_valid (in_valid),
    .in_blank (in_blank),
    .in_index (in_index),
    .out_valid(out_valid),
    .out_blank(out_blank),
    .out_data (out_data)
  );

  // Stimulus helpers: called at a negedge, return at a negedge.
  task automatic wr(input logic [7:0] a, input logic [23:0] d, input logic [2:0] m);
    wen = 1'b1; waddr = a; wdata = d; wmask = m;
    @(negedge clk);
    wen = 1'b0; wmask = '0;
  endtask

  // Returns at the negedge where the sample's result is on the outputs.
  task automatic issue_read(input logic [7:0] a0, input logic [7:0] a1, input logic blank);
    in_valid = 1'b1; in_blank = blank; in_index = {a1, a0};
    @(negedge clk);
    in_valid = 1'b0; in_blank = 1'b0;
    repeat (L - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_blank !== 1'b0 || out_data !== 48'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%h expected v=0 b=0 d=0",
               out_valid, out_blank, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_write_read();
    wr(8'h10, 24'h123456, 3'b111);
    issue_read(8'h10, 8'h10, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {24'h123456, 24'h123456}) begin
      errors++;
      $display("FAIL write_read: got v=%b d=%h expected v=1 d=%h",
               out_valid, out_data, {24'h123456, 24'h123456});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_read_single_pulse: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_lane_mask();
    wr(8'h20, 24'hAABBCC, 3'b111);
    wr(8'h20, 24'h112233, 3'b010);
    issue_read(8'h20, 8'h10, 1'b0);
    checks++;
    if (out_data !== {24'h123456, 24'hAA22CC}) begin
      errors++;
      $display("FAIL lane_mask: got %h expected %h", out_data, {24'h123456, 24'hAA22CC});
    end
    wr(8'h20, 24'h000000, 3'b000);
    issue_read(8'h20, 8'h20, 1'b0);
    checks++;
    if (out_data !== {24'hAA22CC, 24'hAA22CC}) begin
      errors++;
      $display("FAIL zero_mask_noop: got %h expected %h", out_data, {24'hAA22CC, 24'hAA22CC});
    end
  endtask

  task automatic test_streaming();
    logic [7:0] j0, j1;
    int gaps = 0;
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      j0 = i[7:0];
      wr(j0, {j0, j0, j0}, 3'b111);
    end
    for (int t = 0; t < 259; t++) begin
      if (t < L || t >= 256 + L) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_idle_t%0d: got v=%b expected 0", t, out_valid);
        end
      end else begin
        j0 = 8'(t - L);
        j1 = 8'(255 - (t - L));
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; gaps++;
          $display("FAIL stream_gap_t%0d: got v=%b expected 1", t, out_valid);
        end
        checks++;
        if (out_data !== {j1, j1, j1, j0, j0, j0}) begin
          errors++; bad++;
          if (bad < 5)
            $display("FAIL stream_data_t%0d: got %h expected %h", t, out_data,
                     {j1, j1, j1, j0, j0, j0});
        end
      end
      if (t < 256) begin
        in_valid = 1'b1;
        in_index = {8'(255 - t), 8'(t)};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blank();
    wr(8'h10, 24'h123456, 3'b111);
    issue_read(8'h10, 8'h10, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_blank !== 1'b1 || out_data !== 48'h0) begin
      errors++;
      $display("FAIL blank: got v=%b b=%b d=%h expected v=1 b=1 d=0",
               out_valid, out_blank, out_data);
    end
    issue_read(8'h10, 8'h55, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_blank !== 1'b0 || out_data !== {24'h555555, 24'h123456}) begin
      errors++;
      $display("FAIL unblank: got v=%b b=%b d=%h expected v=1 b=0 d=%h",
               out_valid, out_blank, out_data, {24'h555555, 24'h123456});
    end
  endtask

  task automatic test_collision();
    logic [23:0] exp0;
`ifdef DVI_PALETTE_WR_FORWARD_EN
    exp0 = 24'hFFFFFF;
`else
    exp0 = 24'h000000;
`endif
    wr(8'h30, 24'h000000, 3'b111);
    wen = 1'b1; waddr = 8'h30; wdata = 24'hFFFFFF; wmask = 3'b111;
    in_valid = 1'b1; in_index = {8'h31, 8'h30};
    @(negedge clk);
    wen = 1'b0; wmask = '0;
    in_index = {8'h30, 8'h30};
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_data !== {24'h313131, exp0}) begin
      errors++;
      $display("FAIL collision_same_edge: got %h expected %h", out_data, {24'h313131, exp0});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {24'hFFFFFF, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL collision_next_cycle: got v=%b d=%h expected v=1 d=%h",
               out_valid, out_data, {24'hFFFFFF, 24'hFFFFFF});
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_index = {8'h44, 8'h10};
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pipe_full: got v=%b expected 1", out_valid);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 48'h0) begin
      errors++;
      $display("FAIL midrst_async_clear: got v=%b d=%h expected v=0 d=0", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale_%0d: got v=%b expected 0", i, out_valid);
      end
    end
    in_valid = 1'b1; in_index = {8'h10, 8'h10};
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_latency_early: got v=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== {24'h123456, 24'h123456}) begin
      errors++;
      $display("FAIL midrst_contents: got v=%b d=%h expected v=1 d=%h",
               out_valid, out_data, {24'h123456, 24'h123456});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_lane_mask();
    test_streaming();
    test_blank();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
